seven_seg_mux: RTL and testbench

- Parametrised, time-multiplexed hex driver for a common-anode multi-digit seven-segment display.
- Drives the segment bus and digit-select lines of the IO shield from cu_top.
- Decodes 4-bit nibbles to hex glyphs with per-digit decimal point, enable and leading-zero suppression.
- Double-buffers input values so a new value is only shown from a frame boundary onward, which prevents tearing.

---
 rtl/seven_seg_mux.sv | 149 ++++++++++++++
 tb/tb_seven_seg_mux.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex driver for a multi-digit seven-segment display.
// Inputs are double-buffered and take effect only at a frame boundary.
module seven_seg_mux #(
  parameter int DIGITS       = 4,
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 256,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   values,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [DIV_BITS-1:0] BLANK_CNT = DIV_BITS'(BLANK_CYCLES);

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      4'hF: hex_glyph = 7'h71;
      default: hex_glyph = 7'h00;
    endcase
  endfunction

  logic [DIV_BITS-1:0] presc_r;
  logic [IDX_W-1:0]    idx_r;
  logic                frame_done_r;
  logic [7:0]          seg_r;
  logic [DIGITS-1:0]   sel_r;

  logic [4*DIGITS-1:0] pend_values_r, act_values_r;
  logic [DIGITS-1:0]   pend_dp_r, act_dp_r;
  logic [DIGITS-1:0]   pend_en_r, act_en_r;
  logic                pend_lz_r, act_lz_r;
  logic                pend_valid_r;

  logic                terminal_s;
  logic                wrap_s;
  logic                zero_run_s;
  logic [DIGITS-1:0]   lz_blank_s;
  logic [3:0]          nib_s;
  logic                blank_s;
  logic [7:0]          seg_next_s;
  logic [DIGITS-1:0]   sel_next_s;

  // Slot timing: end of slot and end of frame.
  always_comb begin
    terminal_s = &presc_r;
    wrap_s     = terminal_s && (idx_r == LAST_IDX);
  end

  // A digit is a leading zero when it and every more-significant digit are zero or disabled.
  always_comb begin
    lz_blank_s = '0;
    zero_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s    = zero_run_s & ((act_values_r[4*i +: 4] == 4'h0) | ~act_en_r[i]);
      lz_blank_s[i] = act_lz_r & zero_run_s;
    end
  end

  // Next segment/select pattern for the digit currently addressed.
  always_comb begin
    nib_s   = act_values_r[{idx_r, 2'b00} +: 4];
    blank_s = ~act_en_r[idx_r] | lz_blank_s[idx_r];
    if (blank_s) begin
      seg_next_s = 8'h00;
    end else begin
      seg_next_s = {act_dp_r[idx_r], hex_glyph(nib_s)};
    end
    sel_next_s = '0;
    if (presc_r >= BLANK_CNT) begin
      sel_next_s[idx_r] = 1'b1;
    end else begin
      sel_next_s = '0;
    end
  end

  // Prescaler, digit scan, double buffer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r       <= '0;
      idx_r         <= '0;
      frame_done_r  <= 1'b0;
      seg_r         <= 8'h00;
      sel_r         <= '0;
      pend_values_r <= '0;
      pend_dp_r     <= '0;
      pend_en_r     <= '0;
      pend_lz_r     <= 1'b0;
      pend_valid_r  <= 1'b0;
      act_values_r  <= '0;
      act_dp_r      <= '0;
      act_en_r      <= '0;
      act_lz_r      <= 1'b0;
    end else begin
      presc_r      <= presc_r + DIV_BITS'(1);
      frame_done_r <= wrap_s;
      seg_r        <= seg_next_s;
      sel_r        <= sel_next_s;
      if (terminal_s) begin
        idx_r <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
      end
      if (wrap_s && pend_valid_r) begin
        act_values_r <= pend_values_r;
        act_dp_r     <= pend_dp_r;
        act_en_r     <= pend_en_r;
        act_lz_r     <= pend_lz_r;
      end
      // A load on the wrap edge lands in pending and waits for the next frame.
      if (load) begin
        pend_values_r <= values;
        pend_dp_r     <= dp;
        pend_en_r     <= dig_en;
        pend_lz_r     <= lz_en;
        pend_valid_r  <= 1'b1;
      end else if (wrap_s) begin
        pend_valid_r  <= 1'b0;
      end
    end
  end

  assign seg        = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;
  assign sel        = (ACTIVE_LOW != 0) ? ~sel_r : sel_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Randomized and directed bench for seven_seg_mux against a frame-level model.
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        rst, rst8;
  logic [15:0] values;
  logic [3:0]  dp, dig_en;
  logic        lz_en, load;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        frame_done;

  logic [31:0] values8;
  logic [7:0]  dp8, en8;
  logic        lz8, load8;
  logic [7:0]  seg8;
  logic [7:0]  sel8;
  logic        fd8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_mux #(.DIGITS(4), .DIV_BITS(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .values(values), .dp(dp), .dig_en(dig_en), .lz_en(lz_en),
    .load(load), .seg(seg), .sel(sel), .frame_done(frame_done));

  seven_seg_mux #(.DIGITS(8), .DIV_BITS(3), .BLANK_CYCLES(1), .ACTIVE_LOW(0)) dut8 (
    .clk(clk), .rst(rst8), .values(values8), .dp(dp8), .dig_en(en8), .lz_en(lz8),
    .load(load8), .seg(seg8), .sel(sel8), .frame_done(fd8));

  // Reference model: edges since reset, pending and displayed frame contents.
  logic [6:0]  glyph [16];
  int          n;
  logic [15:0] mv, av;
  logic [3:0]  md, ad, me, ae;
  logic        ml, al, pv;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_fd;

  function automatic logic [7:0] exp_digit(input logic [15:0] v, input logic [3:0] d,
                                           input logic [3:0] e, input logic lz, input int i);
    logic lead;
    lead = lz && (i > 0);
    for (int j = i; j < 4; j++)
      if (v[4*j +: 4] != 4'h0 && e[j]) lead = 1'b0;
    if (!e[i] || lead) return 8'h00;
    return {d[i], glyph[v[4*i +: 4]]};
  endfunction

  task automatic model_reset();
    n = 0; pv = 1'b0;
    mv = '0; md = '0; me = '0; ml = 1'b0;
    av = '0; ad = '0; ae = '0; al = 1'b0;
  endtask

  // Advance one clock; expected outputs come from the state before the edge.
  task automatic model_tick();
    int p, i;
    @(posedge clk);
    p = n % 16;
    i = (n / 16) % 4;
    exp_seg = ~exp_digit(av, ad, ae, al, i);
    exp_sel = (p >= 2) ? ~(4'b0001 << i) : 4'hF;
    exp_fd  = ((n % 64) == 63);
    if (exp_fd && pv) begin
      av = mv; ad = md; ae = me; al = ml; pv = 1'b0;
    end
    if (load) begin
      mv = values; md = dp; me = dig_en; ml = lz_en; pv = 1'b1;
    end
    n++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                            input logic lz, input logic ld);
    values = v; dp = d; dig_en = e; lz_en = lz; load = ld;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst8 = 1'b1;
    set_inputs(16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
    values8 = '0; dp8 = '0; en8 = '0; lz8 = 1'b0; load8 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (seg !== 8'hFF || sel !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: seg=%h sel=%b fd=%b, want seg=ff sel=1111 fd=0", seg, sel, frame_done);
    end
    rst = 1'b0;
    model_reset();
    repeat (70) begin
      model_tick();
      checks++;
      if (seg !== exp_seg || sel !== exp_sel || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL after_reset n=%0d: seg=%h sel=%b fd=%b, want %h %b %b", n, seg, sel, frame_done, exp_seg, exp_sel, exp_fd);
      end
    end
  endtask

  task automatic test_basic();
    set_inputs(16'h1234, 4'h0, 4'hF, 1'b0, 1'b1);
    repeat (160) begin
      model_tick();
      checks++;
      if (seg !== exp_seg || sel !== exp_sel || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL basic n=%0d: seg=%h sel=%b fd=%b, want %h %b %b", n, seg, sel, frame_done, exp_seg, exp_sel, exp_fd);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Load one edge before the wrap, then mid-frame twice, then on the wrap edge itself.
    for (int step = 0; step < 4; step++) begin
      int target;
      target = (step == 0) ? 62 : (step == 3) ? 63 : 20 + step * 8;
      while ((n % 64) != target) begin
        model_tick();
        checks++;
        if (seg !== exp_seg || sel !== exp_sel || frame_done !== exp_fd) begin
          errors++;
          $display("FAIL back_to_back n=%0d: seg=%h sel=%b fd=%b, want %h %b %b", n, seg, sel, frame_done, exp_seg, exp_sel, exp_fd);
        end
      end
      case (step)
        0: set_inputs(16'hABCD, 4'h5, 4'hF, 1'b0, 1'b1);
        1: set_inputs(16'h7777, 4'hF, 4'hF, 1'b0, 1'b1);
        2: set_inputs(16'h00F1, 4'h0, 4'hF, 1'b0, 1'b1);
        default: set_inputs(16'h9E06, 4'h2, 4'hF, 1'b0, 1'b1);
      endcase
    end
    repeat (200) begin
      model_tick();
      checks++;
      if (seg !== exp_seg || sel !== exp_sel || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL back_to_back n=%0d: seg=%h sel=%b fd=%b, want %h %b %b", n, seg, sel, frame_done, exp_seg, exp_sel, exp_fd);
      end
    end
  endtask

  task automatic test_blanking();
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: set_inputs(16'h0050, 4'b1000, 4'hF, 1'b1, 1'b1);
        1: set_inputs(16'h0000, 4'hF, 4'hF, 1'b1, 1'b1);
        default: set_inputs(16'h8888, 4'hF, 4'b0101, 1'b0, 1'b1);
      endcase
      repeat (140) begin
        model_tick();
        checks++;
        if (seg !== exp_seg || sel !== exp_sel || frame_done !== exp_fd) begin
          errors++;
          $display("FAIL blanking t=%0d n=%0d: seg=%h sel=%b fd=%b, want %h %b %b", t, n, seg, sel, frame_done, exp_seg, exp_sel, exp_fd);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 11) == 0));
      model_tick();
      checks++;
      if (seg !== exp_seg || sel !== exp_sel || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL random n=%0d: seg=%h sel=%b fd=%b, want %h %b %b", n, seg, sel, frame_done, exp_seg, exp_sel, exp_fd);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    set_inputs(16'h1234, 4'hF, 4'hF, 1'b0, 1'b1);
    while ((n % 64) != 37 || !(av == 16'h1234)) begin
      model_tick();
      if (n > 100000) break;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg !== 8'hFF || sel !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: seg=%h sel=%b fd=%b, want seg=ff sel=1111 fd=0", seg, sel, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (140) begin
      model_tick();
      checks++;
      if (seg !== exp_seg || sel !== exp_sel || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL post_mid_reset n=%0d: seg=%h sel=%b fd=%b, want %h %b %b", n, seg, sel, frame_done, exp_seg, exp_sel, exp_fd);
      end
    end
  endtask

  task automatic test_active_high();
    int waited;
    logic [7:0] want_seg, want_sel;
    @(negedge clk);
    rst8 = 1'b0;
    values8 = 32'h0000_000F; dp8 = 8'h00; en8 = 8'hFF; lz8 = 1'b0; load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    waited = 0;
    while (fd8 !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (fd8 !== 1'b1) begin
      errors++;
      $display("FAIL active_high_frame_done: no pulse within 200 cycles, fd=%b want 1", fd8);
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      want_seg = (k / 8 == 0) ? 8'h71 : 8'h3F;
      want_sel = ((k % 8) >= 1) ? (8'h01 << (k / 8)) : 8'h00;
      checks++;
      if (seg8 !== want_seg || sel8 !== want_sel || fd8 !== (k == 63)) begin
        errors++;
        $display("FAIL active_high k=%0d: seg=%h sel=%b fd=%b, want %h %b %b", k, seg8, sel8, fd8, want_seg, want_sel, (k == 63));
      end
    end
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_basic();
    test_back_to_back();
    test_blanking();
    test_random();
    test_reset_mid_frame();
    test_active_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
